// File: rtl/ram_io_responder.sv
// Byte-wide memory-bus responder: RAM, UART RX/TX FIFOs, cycle counter, program-end strobe.
// Latency: writes commit at the sampling edge; read data lands on mem_rdata two edges after the address.
// Backpressure: rdy_out drops when TX has one or fewer free slots; rx_ready drops when RX is full.

// Circular byte FIFO; pointers carry one extra wrap bit so full/empty fall out of the difference.
module io_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  push,
    input  logic [7:0]            push_dat,
    input  logic                  pop,
    output logic                  push_acc,
    output logic                  pop_acc,
    output logic [7:0]            head_dat,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [7:0]          store [0:DEPTH-1];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;

    assign count    = wr_ptr - rd_ptr;
    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign head_dat = store[rd_ptr[DEPTH_LOG2-1:0]];
    assign pop_acc  = pop && !empty;
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign push_acc = push && (!full || pop_acc);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_acc) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_acc)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push_acc && !rst_in) store[wr_ptr[DEPTH_LOG2-1:0]] <= push_dat;
    end
endmodule

module ram_io_responder #(
    parameter int RAM_ADDR_W     = 17,
    parameter int TXQ_DEPTH_LOG2 = 4,
    parameter int RXQ_DEPTH_LOG2 = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_wdata,
    output logic [7:0]  mem_rdata,
    output logic        rdy_out,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        prog_end,
    output logic        tx_overflow
);
    localparam int RAM_SIZE = 1 << RAM_ADDR_W;
    localparam logic [TXQ_DEPTH_LOG2:0] TX_ZERO    = '0;
    localparam logic [TXQ_DEPTH_LOG2:0] TX_ONE     = {{TXQ_DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [TXQ_DEPTH_LOG2:0] TX_RDY_LIM = {1'b1, {TXQ_DEPTH_LOG2{1'b0}}} - TX_ONE;

    typedef enum logic [1:0] {SRC_RAM, SRC_RX, SRC_SNAP, SRC_ZERO} rd_src_t;

    logic [7:0]            ram [0:RAM_SIZE-1];
    logic [7:0]            ram_q;
    logic [RAM_ADDR_W-1:0] ram_idx;
    logic                  io_sel;
    logic [2:0]            io_off;
    logic [31:0]           cycle_cnt;
    logic [31:0]           snapshot;
    logic                  rd_pend;
    rd_src_t               rd_src;
    rd_src_t               rd_src_nxt;
    logic [1:0]            rd_byte;

    logic                      tx_wr, tx_push_acc, tx_pop_acc, tx_empty, tx_full;
    logic [TXQ_DEPTH_LOG2:0]   tx_cnt, tx_cnt_nxt;
    logic                      rx_pop, rx_push_acc, rx_pop_acc, rx_empty, rx_full;
    logic [7:0]                rx_head;
    logic [RXQ_DEPTH_LOG2:0]   rx_cnt;
    logic                      unused_bits;

    assign io_sel      = mem_a[17];
    assign io_off      = mem_a[2:0];
    assign ram_idx     = mem_a[RAM_ADDR_W-1:0];
    assign unused_bits = ^{mem_a[31:18], rx_push_acc, rx_cnt};

    always_comb begin
        rd_src_nxt = SRC_ZERO;
        if (!io_sel)                  rd_src_nxt = SRC_RAM;
        else if (io_off == 3'd0)      rd_src_nxt = SRC_RX;
        else if (io_off[2])           rd_src_nxt = SRC_SNAP;
    end

    // Zero bytes on the TX port are treated as no-ops by the software side.
    assign tx_wr      = mem_wr && io_sel && (io_off == 3'd0) && (mem_wdata != 8'h00);
    assign tx_valid   = !tx_empty;
    assign tx_cnt_nxt = tx_cnt + (tx_push_acc ? TX_ONE : TX_ZERO) - (tx_pop_acc ? TX_ONE : TX_ZERO);

    io_fifo #(.DEPTH_LOG2(TXQ_DEPTH_LOG2)) tx_fifo (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .push     (tx_wr),
        .push_dat (mem_wdata),
        .pop      (tx_ready),
        .push_acc (tx_push_acc),
        .pop_acc  (tx_pop_acc),
        .head_dat (tx_data),
        .empty    (tx_empty),
        .full     (tx_full),
        .count    (tx_cnt)
    );

    assign rx_ready = !rx_full;
    assign rx_pop   = rd_pend && (rd_src == SRC_RX);

    io_fifo #(.DEPTH_LOG2(RXQ_DEPTH_LOG2)) rx_fifo (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .push     (rx_valid),
        .push_dat (rx_data),
        .pop      (rx_pop),
        .push_acc (rx_push_acc),
        .pop_acc  (rx_pop_acc),
        .head_dat (rx_head),
        .empty    (rx_empty),
        .full     (rx_full),
        .count    (rx_cnt)
    );

    // RAM is left out of reset so its contents survive a soft reset.
    always_ff @(posedge clk_in) begin
        if (mem_wr && !io_sel && !rst_in) ram[ram_idx] <= mem_wdata;
        ram_q <= ram[ram_idx];
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cycle_cnt   <= '0;
            snapshot    <= '0;
            rd_pend     <= 1'b0;
            rd_src      <= SRC_ZERO;
            rd_byte     <= '0;
            mem_rdata   <= '0;
            rdy_out     <= 1'b0;
            prog_end    <= 1'b0;
            tx_overflow <= 1'b0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            rd_pend   <= !mem_wr;
            rd_src    <= rd_src_nxt;
            rd_byte   <= io_off[1:0];
            // Only byte 0 re-latches, so a 4..7 read run sees one coherent value.
            if (!mem_wr && io_sel && (io_off == 3'd4)) snapshot <= cycle_cnt;
            if (rd_pend) begin
                unique case (rd_src)
                    SRC_RAM:  mem_rdata <= ram_q;
                    SRC_RX:   mem_rdata <= rx_pop_acc ? rx_head : 8'h00;
                    SRC_SNAP: mem_rdata <= snapshot[{rd_byte, 3'b000} +: 8];
                    default:  mem_rdata <= 8'h00;
                endcase
            end
            rdy_out  <= (tx_cnt_nxt < TX_RDY_LIM);
            prog_end <= mem_wr && io_sel && (io_off == 3'd4);
            if (tx_wr && !tx_push_acc) tx_overflow <= 1'b1;
        end
    end
endmodule
